ifu_fetch_queue: RTL and testbench

Fetch-packet queue between the I-cache response path and the decode instruction buffer. It captures 64-bit, two-instruction fetch packets and presents up to two instructions per cycle on the `ifu_i0_*`/`ifu_i1_*` ports. It mirrors the buffer's accept rule so that no instruction is dropped. It handles packets that start on the second slot, partial acceptance and cross-packet pairing, and it throttles the I-cache through `ifu_fq_ready`.

---
 rtl/ifu_fetch_queue.sv | 123 ++++++++++++
 tb/tb_ifu_fetch_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// Fetch-packet queue between the I-cache response path and the decode
// instruction buffer. Holds two-instruction packets and presents up to two
// instructions per cycle, consuming them with the same accept rule the
// instruction buffer applies so nothing is dropped.
`ifndef LA64_PC_WIDTH
`define LA64_PC_WIDTH 64
`endif
`ifndef LA64_INST_WIDTH
`define LA64_INST_WIDTH 32
`endif

module ifu_fetch_queue #(
  parameter int FQ_DEPTH = 4,
  parameter int PC_W     = `LA64_PC_WIDTH,
  parameter int INST_W   = `LA64_INST_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ic_rsp_valid,
  input  logic [PC_W-1:1]     ic_rsp_pc,
  input  logic [2*INST_W-1:0] ic_rsp_data,
  output logic                ifu_fq_ready,
  input  logic                ifu_flush,
  input  logic                deu_ib2_val,
  input  logic                deu_ib3_val,
  output logic                ifu_i0_valid,
  output logic [PC_W-1:1]     ifu_i0_pc,
  output logic [INST_W-1:0]   ifu_i0_inst,
  output logic                ifu_i1_valid,
  output logic [PC_W-1:1]     ifu_i1_pc,
  output logic [INST_W-1:0]   ifu_i1_inst
);

  localparam int AW = $clog2(FQ_DEPTH);

  // Packet storage: aligned packet address, both instruction words, and
  // the first slot not yet handed to decode.
  logic [PC_W-1:3]     pc_q   [FQ_DEPTH];
  logic [2*INST_W-1:0] data_q [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] lo_q;

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [AW:0]   head, tail, count, pop_n;
  logic [AW-1:0] hi, ni, ti;
  logic          full, empty, n_occ;
  logic          h_lo, n_lo;
  logic          i1_src;
  logic          acc0, acc1, enq;
  logic          pop1, pop2, set_h_lo, set_n_lo;

  function automatic logic [INST_W-1:0] slot_word(
    input logic [2*INST_W-1:0] d,
    input logic                s
  );
    return s ? d[2*INST_W-1:INST_W] : d[INST_W-1:0];
  endfunction

  assign hi    = head[AW-1:0];
  assign ni    = hi + AW'(1);
  assign ti    = tail[AW-1:0];
  assign count = tail - head;
  assign empty = (head == tail);
  assign full  = (hi == ti) && (head[AW] != tail[AW]);
  assign n_occ = (count >= (AW+1)'(2));
  assign h_lo  = lo_q[hi];
  assign n_lo  = lo_q[ni];

  assign ifu_fq_ready = ~full;
  assign enq          = ic_rsp_valid & ~full & ~ifu_flush;

  // Instruction selection: i0 is the head's first live slot; i1 is the
  // head's second slot, or the next packet's first live slot when the head
  // only has slot 1 left.
  assign i1_src       = h_lo ? n_occ : ~empty;
  assign ifu_i0_valid = ~empty & ~ifu_flush;
  assign ifu_i1_valid = i1_src & ~ifu_flush;
  assign ifu_i0_pc    = {pc_q[hi], h_lo, 1'b0};
  assign ifu_i0_inst  = slot_word(data_q[hi], h_lo);
  assign ifu_i1_pc    = h_lo ? {pc_q[ni], n_lo, 1'b0} : {pc_q[hi], 1'b1, 1'b0};
  assign ifu_i1_inst  = h_lo ? slot_word(data_q[ni], n_lo) : slot_word(data_q[hi], 1'b1);

  // Buffer accept rule, mirrored so the queue consumes exactly what decode takes.
  assign acc0 = ifu_i0_valid & ~deu_ib3_val;
  assign acc1 = ifu_i1_valid & ~deu_ib2_val;

  assign pop1     = acc0 & (h_lo | acc1);
  assign pop2     = acc0 & acc1 & h_lo & n_lo;
  assign set_h_lo = acc0 & ~acc1 & ~h_lo;
  assign set_n_lo = acc0 & acc1 & h_lo & ~n_lo;
  assign pop_n    = pop2 ? (AW+1)'(2) : (pop1 ? (AW+1)'(1) : '0);

  // Control state: pointers and per-entry start slot; reset and flush empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || ifu_flush) begin
      head <= '0;
      tail <= '0;
      lo_q <= '0;
    end else begin
      if (enq) begin
        tail     <= tail + (AW+1)'(1);
        lo_q[ti] <= ic_rsp_pc[2];
      end
      if (set_h_lo) lo_q[hi] <= 1'b1;
      if (set_n_lo) lo_q[ni] <= 1'b1;
      head <= head + pop_n;
    end
  end

  // Packet payload capture; payload needs no reset because validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[ti]   <= ic_rsp_pc[PC_W-1:3];
      data_q[ti] <= ic_rsp_data;
    end
  end

  // The instruction buffer fills in order, so it can never take i1 while refusing i0.
  a_acc1_needs_acc0: assert property (@(posedge clk) disable iff (!rst_n) !(acc1 && !acc0));

  // Fetch packets are always 4-byte aligned.
  a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n) !(ic_rsp_valid && ic_rsp_pc[1]));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: aligned stream, second-slot start with
// cross-packet pairing, partial accept, backpressure, flush and reset.
module tb_ifu_fetch_queue;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ic_rsp_valid;
  logic [PC_W-1:1]     ic_rsp_pc;
  logic [2*INST_W-1:0] ic_rsp_data;
  logic                ifu_fq_ready;
  logic                ifu_flush;
  logic                deu_ib2_val;
  logic                deu_ib3_val;
  logic                ifu_i0_valid;
  logic [PC_W-1:1]     ifu_i0_pc;
  logic [INST_W-1:0]   ifu_i0_inst;
  logic                ifu_i1_valid;
  logic [PC_W-1:1]     ifu_i1_pc;
  logic [INST_W-1:0]   ifu_i1_inst;

  int total = 0;
  int bad   = 0;

  ifu_fetch_queue #(.FQ_DEPTH(4), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_rsp_valid (ic_rsp_valid),
    .ic_rsp_pc    (ic_rsp_pc),
    .ic_rsp_data  (ic_rsp_data),
    .ifu_fq_ready (ifu_fq_ready),
    .ifu_flush    (ifu_flush),
    .deu_ib2_val  (deu_ib2_val),
    .deu_ib3_val  (deu_ib3_val),
    .ifu_i0_valid (ifu_i0_valid),
    .ifu_i0_pc    (ifu_i0_pc),
    .ifu_i0_inst  (ifu_i0_inst),
    .ifu_i1_valid (ifu_i1_valid),
    .ifu_i1_pc    (ifu_i1_pc),
    .ifu_i1_inst  (ifu_i1_inst)
  );

  always #5 clk = ~clk;

  wire [63:0] i0_addr = {ifu_i0_pc, 1'b0};
  wire [63:0] i1_addr = {ifu_i1_pc, 1'b0};

  // Instruction word encodes its own address so order and payload are both checked.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v0, input logic [63:0] a0,
                         input logic v1, input logic [63:0] a1);
    chk({tag, ".i0v"}, 64'(ifu_i0_valid), 64'(v0));
    if (v0) begin
      chk({tag, ".i0pc"}, i0_addr, a0);
      chk({tag, ".i0inst"}, 64'(ifu_i0_inst), 64'(inst_of(a0)));
    end
    chk({tag, ".i1v"}, 64'(ifu_i1_valid), 64'(v1));
    if (v1) begin
      chk({tag, ".i1pc"}, i1_addr, a1);
      chk({tag, ".i1inst"}, 64'(ifu_i1_inst), 64'(inst_of(a1)));
    end
  endtask

  task automatic offer(input logic [63:0] a);
    logic [63:0] base;
    base         = a & ~64'h7;
    ic_rsp_valid = 1'b1;
    ic_rsp_pc    = a[63:1];
    ic_rsp_data  = {inst_of(base + 64'd4), inst_of(base)};
  endtask

  task automatic idle_rsp();
    ic_rsp_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    int          n;
    logic        pend;
    logic [63:0] exp_a;

    rst_n = 1'b0; ic_rsp_valid = 1'b0; ic_rsp_pc = '0; ic_rsp_data = '0;
    ifu_flush = 1'b0; deu_ib2_val = 1'b0; deu_ib3_val = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("reset.i0v", 64'(ifu_i0_valid), 64'd0);
    chk("reset.i1v", 64'(ifu_i1_valid), 64'd0);
    chk("reset.ready", 64'(ifu_fq_ready), 64'd1);

    // Aligned stream
    offer(64'h1000); settle();
    chk("t1.c0.i0v", 64'(ifu_i0_valid), 64'd0);
    tick();
    offer(64'h1008); settle();
    chk_out("t1.c1", 1'b1, 64'h1000, 1'b1, 64'h1004);
    tick();
    offer(64'h1010); settle();
    chk_out("t1.c2", 1'b1, 64'h1008, 1'b1, 64'h100C);
    tick();
    idle_rsp(); settle();
    chk_out("t1.c3", 1'b1, 64'h1010, 1'b1, 64'h1014);
    tick();
    settle();
    chk_out("t1.empty", 1'b0, 64'h0, 1'b0, 64'h0);

    // Second-slot start and cross-packet pairing
    offer(64'h2004); tick();
    offer(64'h2008); deu_ib2_val = 1'b1; deu_ib3_val = 1'b1; settle();
    chk_out("t2.c1", 1'b1, 64'h2004, 1'b0, 64'h0);
    tick();
    idle_rsp(); deu_ib2_val = 1'b0; deu_ib3_val = 1'b0; settle();
    chk_out("t2.pair", 1'b1, 64'h2004, 1'b1, 64'h2008);
    tick();
    settle();
    chk_out("t2.next", 1'b1, 64'h200C, 1'b0, 64'h0);
    tick();
    settle();
    chk("t2.empty", 64'(ifu_i0_valid), 64'd0);

    // Partial accept
    offer(64'h3000); tick();
    idle_rsp(); deu_ib2_val = 1'b1; settle();
    chk_out("t3.c1", 1'b1, 64'h3000, 1'b1, 64'h3004);
    tick();
    deu_ib2_val = 1'b0; settle();
    chk_out("t3.c2", 1'b1, 64'h3004, 1'b0, 64'h0);
    tick();
    settle();
    chk("t3.empty", 64'(ifu_i0_valid), 64'd0);

    // Backpressure: decode stalled while five packets are offered
    deu_ib2_val = 1'b1; deu_ib3_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(64'h5000 + 64'(8 * k)); settle();
      chk($sformatf("t4.ready%0d", k), 64'(ifu_fq_ready), 64'd1);
      tick();
    end
    offer(64'h5020); settle();
    chk("t4.full", 64'(ifu_fq_ready), 64'd0);
    tick();
    settle();
    chk("t4.held", 64'(ifu_fq_ready), 64'd0);
    chk_out("t4.headhold", 1'b1, 64'h5000, 1'b1, 64'h5004);
    tick();
    deu_ib2_val = 1'b0; deu_ib3_val = 1'b0;
    n = 0;
    pend = 1'b1;
    for (int cyc = 0; cyc < 20 && n < 10; cyc++) begin
      if (pend) offer(64'h5020); else idle_rsp();
      settle();
      if (cyc == 0) chk("t4.no_early_ready", 64'(ifu_fq_ready), 64'd0);
      if (ifu_i0_valid) begin
        exp_a = 64'h5000 + 64'(4 * n);
        chk($sformatf("t4.i0pc.%0d", n), i0_addr, exp_a);
        chk($sformatf("t4.i0inst.%0d", n), 64'(ifu_i0_inst), 64'(inst_of(exp_a)));
        n++;
        if (ifu_i1_valid) begin
          exp_a = 64'h5000 + 64'(4 * n);
          chk($sformatf("t4.i1pc.%0d", n), i1_addr, exp_a);
          chk($sformatf("t4.i1inst.%0d", n), 64'(ifu_i1_inst), 64'(inst_of(exp_a)));
          n++;
        end
      end
      if (pend && ifu_fq_ready) pend = 1'b0;
      tick();
    end
    idle_rsp();
    chk("t4.count", 64'(n), 64'd10);
    settle();
    chk("t4.empty", 64'(ifu_i0_valid), 64'd0);

    // Flush with three packets queued and a response in the flush cycle
    deu_ib2_val = 1'b1; deu_ib3_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      offer(64'h6000 + 64'(8 * k)); tick();
    end
    offer(64'h7000); ifu_flush = 1'b1; settle();
    chk_out("t5.flushcyc", 1'b0, 64'h0, 1'b0, 64'h0);
    tick();
    ifu_flush = 1'b0; deu_ib2_val = 1'b0; deu_ib3_val = 1'b0;
    offer(64'h4000); settle();
    chk("t5.empty", 64'(ifu_i0_valid), 64'd0);
    chk("t5.ready", 64'(ifu_fq_ready), 64'd1);
    tick();
    idle_rsp(); settle();
    chk_out("t5.after", 1'b1, 64'h4000, 1'b1, 64'h4004);
    tick();
    settle();
    chk("t5.drained", 64'(ifu_i0_valid), 64'd0);

    // Reset mid-operation
    deu_ib2_val = 1'b1; deu_ib3_val = 1'b1;
    offer(64'h8000); tick();
    offer(64'h8008); tick();
    idle_rsp(); settle();
    chk_out("t6.queued", 1'b1, 64'h8000, 1'b1, 64'h8004);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; settle();
    chk("t6.i0v", 64'(ifu_i0_valid), 64'd0);
    chk("t6.i1v", 64'(ifu_i1_valid), 64'd0);
    chk("t6.ready", 64'(ifu_fq_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
